// File: rtl/axi_write_arbiter.sv
// Write-path arbiter for a 3-master AXI interconnect: round-robin on AWVALID, grant held
// for a whole AW/W/B transaction, with an optional stall timeout that forces release.
module axi_write_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       m0_awvalid,
    input  logic       m1_awvalid,
    input  logic       m2_awvalid,
    input  logic       s_awvalid,
    input  logic       m_awready,
    input  logic       s_wvalid,
    input  logic       s_wlast,
    input  logic       m_wready,
    input  logic       m_bvalid,
    input  logic       s_bready,
    output logic [2:0] wr_grant,
    output logic       wr_busy,
    output logic       wr_timeout
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

    localparam logic [CNT_WIDTH-1:0] TimeoutVal = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic                 TimeoutEn  = (TIMEOUT_CYCLES != 0);

    state_e               state_q, state_d;
    logic [2:0]           grant_q, grant_d;
    logic [2:0]           last_q, last_d;
    logic                 w_done_q, w_done_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] counter_q, counter_d;

    logic [2:0] req;
    logic [2:0] winner;
    logic       aw_hs, w_beat, wl_hs, b_hs;

    assign req    = {m2_awvalid, m1_awvalid, m0_awvalid};
    assign aw_hs  = s_awvalid & m_awready;
    assign w_beat = s_wvalid & m_wready;
    assign wl_hs  = w_beat & s_wlast;
    assign b_hs   = m_bvalid & s_bready;

    // Search starts at the master after the last winner.
    always_comb begin
        winner = 3'b000;
        case (last_q)
            3'b001: begin
                if (req[1])      winner = 3'b010;
                else if (req[2]) winner = 3'b100;
                else if (req[0]) winner = 3'b001;
            end
            3'b010: begin
                if (req[2])      winner = 3'b100;
                else if (req[0]) winner = 3'b001;
                else if (req[1]) winner = 3'b010;
            end
            default: begin
                if (req[0])      winner = 3'b001;
                else if (req[1]) winner = 3'b010;
                else if (req[2]) winner = 3'b100;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        w_done_d  = w_done_q;
        timeout_d = 1'b0;

        if (state_q == StIdle || aw_hs || w_beat || b_hs) begin
            counter_d = '0;
        end else if (counter_q != '1) begin
            counter_d = counter_q + CNT_WIDTH'(1);
        end else begin
            counter_d = counter_q;
        end

        case (state_q)
            StIdle: begin
                if (winner != 3'b000) begin
                    grant_d = winner;
                    last_d  = winner;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                // W may complete before or together with AW; remember it so DATA is skipped.
                if (wl_hs) w_done_d = 1'b1;
                if (aw_hs) state_d = (w_done_q || wl_hs) ? StResp : StData;
            end
            StData: begin
                if (wl_hs) state_d = StResp;
            end
            StResp: begin
                if (b_hs) begin
                    state_d  = StIdle;
                    grant_d  = 3'b000;
                    w_done_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Timed-out master stays in last_q, so it drops to lowest priority.
        if (TimeoutEn && state_q != StIdle && counter_q == TimeoutVal) begin
            state_d   = StIdle;
            grant_d   = 3'b000;
            w_done_d  = 1'b0;
            timeout_d = 1'b1;
            counter_d = '0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q   <= StIdle;
            grant_q   <= 3'b000;
            last_q    <= 3'b100;
            w_done_q  <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            w_done_q  <= w_done_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            counter_q <= counter_d;
        end
    end

    assign wr_grant   = grant_q;
    assign wr_busy    = busy_q;
    assign wr_timeout = timeout_q;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: a per-cycle vector table plus hand-written
// sequences for round-robin, timeout, asynchronous reset and disabled timeout.
module tb_axi_write_arbiter;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic m0_awvalid = 1'b0, m1_awvalid = 1'b0, m2_awvalid = 1'b0;
    logic s_awvalid = 1'b0, m_awready = 1'b0;
    logic s_wvalid = 1'b0, s_wlast = 1'b0, m_wready = 1'b0;
    logic m_bvalid = 1'b0, s_bready = 1'b0;

    logic [2:0] grant_d, grant_8, grant_z;
    logic       busy_d, busy_8, busy_z;
    logic       to_d, to_8, to_z;

    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    axi_write_arbiter u_dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_awvalid(m0_awvalid), .m1_awvalid(m1_awvalid), .m2_awvalid(m2_awvalid),
        .s_awvalid(s_awvalid), .m_awready(m_awready),
        .s_wvalid(s_wvalid), .s_wlast(s_wlast), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .s_bready(s_bready),
        .wr_grant(grant_d), .wr_busy(busy_d), .wr_timeout(to_d)
    );

    axi_write_arbiter #(.TIMEOUT_CYCLES(8), .CNT_WIDTH(16)) u_dut8 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_awvalid(m0_awvalid), .m1_awvalid(m1_awvalid), .m2_awvalid(m2_awvalid),
        .s_awvalid(s_awvalid), .m_awready(m_awready),
        .s_wvalid(s_wvalid), .s_wlast(s_wlast), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .s_bready(s_bready),
        .wr_grant(grant_8), .wr_busy(busy_8), .wr_timeout(to_8)
    );

    axi_write_arbiter #(.TIMEOUT_CYCLES(0), .CNT_WIDTH(16)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m0_awvalid(m0_awvalid), .m1_awvalid(m1_awvalid), .m2_awvalid(m2_awvalid),
        .s_awvalid(s_awvalid), .m_awready(m_awready),
        .s_wvalid(s_wvalid), .s_wlast(s_wlast), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .s_bready(s_bready),
        .wr_grant(grant_z), .wr_busy(busy_z), .wr_timeout(to_z)
    );

    typedef struct {
        logic [2:0] req;
        logic       awv, awr, wv, wl, wr, bv, br;
        logic [2:0] g;
        logic       busy;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(logic [2:0] req, logic awv, logic awr, logic wv, logic wl,
                                logic wr, logic bv, logic br, logic [2:0] g, logic busy);
        vec_t v;
        v.req = req; v.awv = awv; v.awr = awr; v.wv = wv; v.wl = wl; v.wr = wr;
        v.bv = bv; v.br = br; v.g = g; v.busy = busy;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [2:0] req, logic awv, logic awr, logic wv, logic wl,
                         logic wr, logic bv, logic br);
        {m2_awvalid, m1_awvalid, m0_awvalid} = req;
        s_awvalid = awv; m_awready = awr;
        s_wvalid = wv; s_wlast = wl; m_wready = wr;
        m_bvalid = bv; s_bready = br;
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        drive(3'b000, 0, 0, 0, 0, 0, 0, 0);
        sys_rst = 1'b1;
        step();
        step();
        sys_rst = 1'b0;
    endtask

    initial begin
        int k;
        int n_to_z, n_to_d;

        vecs[0]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        vecs[1]  = mk(3'b001, 0, 0, 0, 0, 0, 0, 0, 3'b001, 1);
        vecs[2]  = mk(3'b001, 1, 1, 0, 0, 0, 0, 0, 3'b001, 1);
        vecs[3]  = mk(3'b000, 0, 0, 1, 0, 1, 0, 0, 3'b001, 1);
        vecs[4]  = mk(3'b000, 0, 0, 1, 0, 1, 0, 0, 3'b001, 1);
        vecs[5]  = mk(3'b000, 0, 0, 1, 0, 1, 0, 0, 3'b001, 1);
        vecs[6]  = mk(3'b000, 0, 0, 1, 1, 1, 0, 0, 3'b001, 1);
        vecs[7]  = mk(3'b000, 0, 0, 0, 0, 0, 1, 0, 3'b001, 1);
        vecs[8]  = mk(3'b000, 0, 0, 0, 0, 0, 1, 1, 3'b000, 0);
        vecs[9]  = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        vecs[10] = mk(3'b110, 0, 0, 0, 0, 0, 0, 0, 3'b010, 1);
        vecs[11] = mk(3'b110, 1, 1, 1, 1, 1, 0, 0, 3'b010, 1);
        vecs[12] = mk(3'b000, 0, 0, 0, 0, 0, 1, 1, 3'b000, 0);
        vecs[13] = mk(3'b101, 0, 0, 0, 0, 0, 0, 0, 3'b100, 1);
        vecs[14] = mk(3'b000, 0, 0, 1, 1, 1, 0, 0, 3'b100, 1);
        vecs[15] = mk(3'b000, 1, 1, 0, 0, 0, 0, 0, 3'b100, 1);
        vecs[16] = mk(3'b000, 0, 0, 0, 0, 0, 1, 1, 3'b000, 0);
        vecs[17] = mk(3'b111, 0, 0, 0, 0, 0, 0, 0, 3'b001, 1);
        vecs[18] = mk(3'b000, 0, 0, 1, 0, 1, 0, 0, 3'b001, 1);
        vecs[19] = mk(3'b000, 1, 1, 0, 0, 0, 0, 0, 3'b001, 1);
        vecs[20] = mk(3'b000, 0, 0, 0, 0, 0, 1, 1, 3'b001, 1);
        vecs[21] = mk(3'b000, 0, 0, 1, 1, 1, 0, 0, 3'b001, 1);
        vecs[22] = mk(3'b000, 0, 0, 0, 0, 0, 1, 1, 3'b000, 0);

        // Reset state, observed while reset is asserted.
        #1;
        chk("reset_grant", 32'(grant_d), 32'(3'b000));
        chk("reset_busy", 32'(busy_d), 32'(1'b0));
        chk("reset_timeout", 32'(to_d), 32'(1'b0));
        chk("reset_grant_t8", 32'(grant_8), 32'(3'b000));
        chk("reset_grant_t0", 32'(grant_z), 32'(3'b000));
        do_reset();

        // Vector table: basic transaction, round-robin order, W-before-AW and same-cycle paths.
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].req, vecs[i].awv, vecs[i].awr, vecs[i].wv, vecs[i].wl,
                  vecs[i].wr, vecs[i].bv, vecs[i].br);
            step();
            chk($sformatf("vec%0d_grant", i), 32'(grant_d), 32'(vecs[i].g));
            chk($sformatf("vec%0d_busy", i), 32'(busy_d), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_timeout", i), 32'(to_d), 32'(1'b0));
        end

        // Continuous requests from all masters: 001, 010, 100, 001 with a 000 gap.
        do_reset();
        begin
            logic [2:0] exp_seq [4];
            exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100; exp_seq[3] = 3'b001;
            for (int t = 0; t < 4; t++) begin
                drive(3'b111, 0, 0, 0, 0, 0, 0, 0);
                k = 0;
                do begin
                    step();
                    k++;
                end while (grant_d == 3'b000 && k < 5);
                chk($sformatf("rr%0d_latency", t), 32'(k), 32'd1);
                chk($sformatf("rr%0d_grant", t), 32'(grant_d), 32'(exp_seq[t]));
                drive(3'b111, 1, 1, 1, 1, 1, 0, 0);
                step();
                drive(3'b111, 0, 0, 0, 0, 0, 1, 1);
                step();
                chk($sformatf("rr%0d_gap", t), 32'(grant_d), 32'(3'b000));
            end
        end

        // Timeout (instance with TIMEOUT_CYCLES = 8): AWREADY never comes.
        do_reset();
        drive(3'b110, 1, 0, 0, 0, 0, 0, 0);
        step();
        chk("to_first_grant", 32'(grant_8), 32'(3'b010));
        k = 0;
        while (!to_8 && k < 20) begin
            step();
            k++;
        end
        chk("to_pulse_seen", 32'(to_8), 32'(1'b1));
        chk("to_delay_in_window", 32'((k >= 8) && (k <= 9)), 32'd1);
        chk("to_grant_released", 32'(grant_8), 32'(3'b000));
        chk("to_busy_low", 32'(busy_8), 32'(1'b0));
        step();
        chk("to_single_pulse", 32'(to_8), 32'(1'b0));
        chk("to_next_grant_m2", 32'(grant_8), 32'(3'b100));

        // Asynchronous reset mid-DATA, then m2 alone.
        do_reset();
        drive(3'b001, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(3'b000, 1, 1, 0, 0, 0, 0, 0);
        step();
        drive(3'b000, 0, 0, 1, 0, 1, 0, 0);
        step();
        chk("arst_pre_grant", 32'(grant_d), 32'(3'b001));
        drive(3'b100, 0, 0, 0, 0, 0, 0, 0);
        #2;
        sys_rst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant_d), 32'(3'b000));
        chk("arst_busy", 32'(busy_d), 32'(1'b0));
        @(negedge sys_clk);
        sys_rst = 1'b0;
        step();
        chk("arst_m2_grant", 32'(grant_d), 32'(3'b100));

        // Disabled timeout: B channel stalled for 5000 cycles.
        do_reset();
        drive(3'b001, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(3'b000, 1, 1, 1, 1, 1, 0, 0);
        step();
        drive(3'b000, 0, 0, 0, 0, 0, 1, 0);
        n_to_z = 0;
        n_to_d = 0;
        for (int c = 0; c < 5000; c++) begin
            step();
            if (to_z) n_to_z++;
            if (to_d) n_to_d++;
        end
        chk("t0_no_timeout", 32'(n_to_z), 32'd0);
        chk("t0_grant_held", 32'(grant_z), 32'(3'b001));
        chk("t0_busy_held", 32'(busy_z), 32'(1'b1));
        chk("t1024_one_timeout", 32'(n_to_d), 32'd1);
        chk("t1024_released", 32'(grant_d), 32'(3'b000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
